// File: rtl/unary_bin_dec_pkg.sv
// Shared types and helpers for the unary-stream datapath.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } decState_e;

  // An all-ones window counts exactly 2^winLog, one past what bitWidth bits
  // can hold after the shift, so it clips to the maximum code.
  function automatic logic [31:0] scaleDown(input logic [31:0] ones,
                                            input int unsigned winLog,
                                            input int unsigned bitWidth);
    logic [31:0] full;
    logic [31:0] maxOut;
    full   = 32'd1 << winLog;
    maxOut = (32'd1 << bitWidth) - 32'd1;
    if (ones >= full) return maxOut;
    return ones >> (winLog - bitWidth);
  endfunction

endpackage

// File: rtl/unary_bin_dec_if.sv
// Control, bitstream and result signals of the unary-to-binary decoder.
interface unary_bin_dec_if #(
  parameter int unsigned BITWIDTH = 8
);
  logic                iStart;
  logic                iEn;
  logic                iClr;
  logic                iBit;
  logic [BITWIDTH-1:0] oValue;
  logic                oValid;
  logic                oBusy;

  modport master (
    output iStart, iEn, iClr, iBit,
    input  oValue, oValid, oBusy
  );

  modport slave (
    input  iStart, iEn, iClr, iBit,
    output oValue, oValid, oBusy
  );
endinterface

// File: rtl/unary_win_cnt.sv
// Enable-gated window counter with synchronous clear; flags the final sample.
module unary_win_cnt #(
  parameter int unsigned WINLOG = 8
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iClr,
  input  logic iEn,
  output logic oLast
);

  logic [WINLOG-1:0] win;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      win <= '0;
    end else if (iClr) begin
      win <= '0;
    end else if (iEn) begin
      win <= win + WINLOG'(1);
    end
  end

  assign oLast = iEn && (win == '1);

endmodule

// File: rtl/unary_bin_dec.sv
// Counts '1' samples of a unary stream over 2^WINLOG enabled cycles and
// returns the scaled binary magnitude with a one-cycle valid pulse.
module unary_bin_dec
  import unary_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned WINLOG   = 8
) (
  input logic           iClk,
  input logic           iRstN,
  unary_bin_dec_if.slave bus
);

  decState_e   state;
  decState_e   nextState;
  logic [WINLOG:0] ones;
  logic        startWin;
  logic        winEn;
  logic        winClr;
  logic        winLast;

  // A window opens from IDLE or straight out of DONE; iClr overrides it.
  assign startWin = bus.iStart && !bus.iClr && (state != ACCUM);
  assign winEn    = (state == ACCUM) && bus.iEn;
  assign winClr   = bus.iClr || startWin;

  unary_win_cnt #(
    .WINLOG(WINLOG)
  ) uWinCnt (
    .iClk (iClk),
    .iRstN(iRstN),
    .iClr (winClr),
    .iEn  (winEn),
    .oLast(winLast)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.iStart) nextState = ACCUM;
      ACCUM:   if (winLast) nextState = DONE;
      DONE:    nextState = bus.iStart ? ACCUM : IDLE;
      default: nextState = IDLE;
    endcase
    if (bus.iClr) nextState = IDLE;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ones <= '0;
    end else if (bus.iClr || startWin) begin
      ones <= '0;
    end else if (winEn) begin
      ones <= ones + (WINLOG+1)'(bus.iBit);
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      bus.oValue <= '0;
      bus.oValid <= 1'b0;
    end else if (bus.iClr) begin
      bus.oValue <= '0;
      bus.oValid <= 1'b0;
    end else begin
      bus.oValid <= (state == DONE);
      if (state == DONE) begin
        bus.oValue <= BITWIDTH'(scaleDown(32'(ones), WINLOG, BITWIDTH));
      end
    end
  end

  assign bus.oBusy = (state == ACCUM);

endmodule

// File: tb/tb_unary_bin_dec.sv
// Bench for unary_bin_dec: 8-bit and 6-bit result instances share one
// stimulus stream and are compared against a proportion-of-ones model.
module tb_unary_bin_dec;

  localparam int unsigned WINLOG  = 8;
  localparam int unsigned WINLEN  = 1 << WINLOG;
  localparam int unsigned NOPAUSE = 1 << 20;

  logic iClk   = 1'b0;
  logic iRstN  = 1'b0;
  logic iStart = 1'b0;
  logic iEn    = 1'b0;
  logic iClr   = 1'b0;
  logic iBit   = 1'b0;

  int unsigned nChecks = 0;
  int unsigned nBad    = 0;
  int unsigned prev8   = 0;
  int unsigned prev6   = 0;
  logic        stim [WINLEN];

  unary_bin_dec_if #(.BITWIDTH(8)) bus8 ();
  unary_bin_dec_if #(.BITWIDTH(6)) bus6 ();

  assign bus8.iStart = iStart;
  assign bus8.iEn    = iEn;
  assign bus8.iClr   = iClr;
  assign bus8.iBit   = iBit;
  assign bus6.iStart = iStart;
  assign bus6.iEn    = iEn;
  assign bus6.iClr   = iClr;
  assign bus6.iBit   = iBit;

  unary_bin_dec #(.BITWIDTH(8), .WINLOG(WINLOG)) dut8 (
    .iClk (iClk),
    .iRstN(iRstN),
    .bus  (bus8)
  );

  unary_bin_dec #(.BITWIDTH(6), .WINLOG(WINLOG)) dut6 (
    .iClk (iClk),
    .iRstN(iRstN),
    .bus  (bus6)
  );

  always #5 iClk = ~iClk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=still running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
    nChecks++;
    if (got != exp) begin
      nBad++;
      $display("FAIL %s: got=%0d required=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Decoded magnitude is the fraction of ones in the window, expressed in
  // bw-bit full scale and clipped to the largest code.
  function automatic int unsigned refScale(input int unsigned ones, input int unsigned bw);
    int unsigned full;
    int unsigned q;
    full = 1 << bw;
    q    = (ones * full) / WINLEN;
    if (q > full - 1) q = full - 1;
    return q;
  endfunction

  task automatic runWin(input string tag, input bit startDone, input bit holdStart,
                        input int unsigned pauseAt, input int unsigned pauseLen);
    int unsigned ones  = 0;
    int unsigned stray = 0;
    int unsigned e8;
    int unsigned e6;
    for (int i = 0; i < WINLEN; i++) ones += 32'(stim[i]);
    e8 = refScale(ones, 8);
    e6 = refScale(ones, 6);
    if (!startDone) begin
      iStart = 1'b1;
      tick();
      checkVal({tag, "_busyStart"}, 32'(bus8.oBusy), 1);
    end
    iStart = holdStart;
    for (int i = 0; i < WINLEN; i++) begin
      if (i == pauseAt) begin
        iEn  = 1'b0;
        iBit = 1'b1;
        for (int p = 0; p < pauseLen; p++) begin
          tick();
          if (!bus8.oBusy || bus8.oValid || bus6.oValid) stray++;
        end
      end
      iEn  = 1'b1;
      iBit = stim[i];
      tick();
      if (bus8.oValid || bus6.oValid) stray++;
      if (32'(bus8.oValue) != prev8 || 32'(bus6.oValue) != prev6) stray++;
      if (bus8.oBusy != (i != WINLEN - 1) || bus6.oBusy != bus8.oBusy) stray++;
    end
    iBit = 1'($urandom);
    tick();
    checkVal({tag, "_stray"}, stray, 0);
    checkVal({tag, "_valid8"}, 32'(bus8.oValid), 1);
    checkVal({tag, "_valid6"}, 32'(bus6.oValid), 1);
    checkVal({tag, "_value8"}, 32'(bus8.oValue), e8);
    checkVal({tag, "_value6"}, 32'(bus6.oValue), e6);
    checkVal({tag, "_busyDone"}, 32'(bus8.oBusy), 32'(holdStart));
    prev8 = e8;
    prev6 = e6;
    if (!holdStart) begin
      iStart = 1'b0;
      tick();
      checkVal({tag, "_pulse"}, 32'(bus8.oValid), 0);
      checkVal({tag, "_hold8"}, 32'(bus8.oValue), e8);
    end
  endtask

  initial begin
    #12;
    checkVal("rst_value8", 32'(bus8.oValue), 0);
    checkVal("rst_value6", 32'(bus6.oValue), 0);
    checkVal("rst_valid", 32'(bus8.oValid), 0);
    checkVal("rst_busy", 32'(bus8.oBusy), 0);
    iRstN = 1'b1;

    for (int i = 0; i < WINLEN; i++) stim[i] = 1'b1;
    runWin("allOnes", 1'b0, 1'b0, NOPAUSE, 0);

    for (int i = 0; i < WINLEN; i++) stim[i] = (i < 134);
    runWin("first134", 1'b0, 1'b0, NOPAUSE, 0);
    for (int i = 0; i < WINLEN; i++) stim[i] = (i % 2 == 0);
    runWin("alternate", 1'b0, 1'b0, NOPAUSE, 0);
    for (int i = 0; i < WINLEN; i++) stim[i] = 1'b0;
    runWin("allZero", 1'b0, 1'b0, NOPAUSE, 0);

    for (int i = 0; i < WINLEN; i++) stim[i] = 1'($urandom);
    runWin("pause500", 1'b0, 1'b0, 77, 500);

    for (int i = 0; i < WINLEN; i++) stim[i] = (i < 64);
    runWin("b2bFirst", 1'b0, 1'b1, NOPAUSE, 0);
    for (int i = 0; i < WINLEN; i++) stim[i] = (i < 200);
    runWin("b2bSecond", 1'b1, 1'b0, NOPAUSE, 0);

    begin : clrTest
      int unsigned stray = 0;
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      iEn    = 1'b1;
      for (int i = 0; i < 100; i++) begin
        iBit = 1'($urandom);
        tick();
      end
      checkVal("preClr_value8", 32'(bus8.oValue), prev8);
      iClr = 1'b1;
      tick();
      iClr = 1'b0;
      checkVal("clr_busy", 32'(bus8.oBusy), 0);
      checkVal("clr_value8", 32'(bus8.oValue), 0);
      checkVal("clr_value6", 32'(bus6.oValue), 0);
      checkVal("clr_valid", 32'(bus8.oValid), 0);
      prev8 = 0;
      prev6 = 0;
      for (int i = 0; i < 300; i++) begin
        iBit = 1'($urandom);
        tick();
        if (bus8.oValid || bus8.oBusy || bus6.oValid) stray++;
      end
      checkVal("clr_quiet", stray, 0);
      iStart = 1'b1;
      iClr   = 1'b1;
      tick();
      iStart = 1'b0;
      iClr   = 1'b0;
      checkVal("startClr_busy", 32'(bus8.oBusy), 0);
      tick();
      checkVal("startClr_idle", 32'(bus8.oBusy), 0);
    end

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < WINLEN; i++) stim[i] = 1'($urandom);
      runWin($sformatf("rand%0d", r), 1'b0, 1'b0, $urandom_range(0, WINLEN - 1),
             $urandom_range(1, 20));
    end

    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    iEn    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      iBit = 1'($urandom);
      tick();
    end
    #2 iRstN = 1'b0;
    #1;
    checkVal("arst_value8", 32'(bus8.oValue), 0);
    checkVal("arst_value6", 32'(bus6.oValue), 0);
    checkVal("arst_valid", 32'(bus8.oValid), 0);
    checkVal("arst_busy", 32'(bus8.oBusy), 0);
    #2 iRstN = 1'b1;
    prev8 = 0;
    prev6 = 0;
    for (int i = 0; i < WINLEN; i++) stim[i] = (i < 134);
    runWin("afterRst", 1'b0, 1'b0, NOPAUSE, 0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/unary_bin_dec.md
Name: unary_bin_dec

Overview:
Bitstream-to-binary decoder for the unary (rate-coded) multiplier datapath. It is the receiving end of the uMUL output: it counts '1' samples of a serial unary stream over a window of 2^WINLOG enabled cycles and returns the binary magnitude with a one-cycle valid pulse. It sits after the unary multiplier to bring results back into the binary domain for checking or storage.

Parameters:
BITWIDTH, 8, width of the decoded binary result.
WINLOG, 8, log2 of window length in enabled samples; must be >= BITWIDTH.

Ports:
iClk  input  1  clock, rising-edge.
iRstN  input  1  asynchronous active-low reset.
iStart  input  1  begin a new decode window.
iEn  input  1  sample enable; low pauses the window.
iClr  input  1  synchronous abort/clear.
iBit  input  1  unary bitstream sample.
oValue  output  BITWIDTH  decoded result, held until the next result or clear.
oValid  output  1  one-cycle pulse when oValue updates.
oBusy  output  1  high while a window is in progress (ACCUM).

Behaviour:
- Reset (iRstN=0, async): state IDLE; ones counter, window counter, oValue, oValid and oBusy all 0.
- FSM states:
  - IDLE -> ACCUM on iStart=1.
  - ACCUM -> DONE after the last enabled sample.
  - DONE -> IDLE, or DONE -> ACCUM if iStart=1 in DONE (back-to-back windows).
- Entering ACCUM clears the ones counter (WINLOG+1 bits) and the window counter (WINLOG bits).
- ACCUM, iEn=1, per edge:
  - ones += iBit; win += 1.
  - The sample taken when win == 2^WINLOG-1 is the last one; the next state is DONE.
- ACCUM, iEn=0: both counters frozen, state held; no timeout.
- iStart in ACCUM is ignored.
- DONE:
  - oValue <= ones >> (WINLOG-BITWIDTH), saturated to 2^BITWIDTH-1 when ones == 2^WINLOG (all-ones stream).
  - oValid = 1 for exactly this cycle.
  - oValue is registered, so it changes on the same edge that raises oValid.
- Latency with iEn held high:
  - iStart sampled at edge k; samples are taken at edges k+1 .. k+2^WINLOG.
  - oValid is high during the cycle after edge k+2^WINLOG+1.
- oBusy = (state == ACCUM).
- iClr (synchronous, highest priority above iStart and iEn):
  - Next state IDLE; counters, oValue and oValid cleared to 0.
  - Mid-window iClr produces no oValid.
- Async reset mid-window: same end result as iClr, but immediate.
- Arithmetic is unsigned; the ones counter cannot overflow, because it is WINLOG+1 bits wide.

Decomposition:
- Shared package unary_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - Function for the saturating scale-down from WINLOG+1 bits to BITWIDTH.
- One natural sub-module, unary_win_cnt:
  - Enable-gated window counter with clear.
  - Outputs a last-sample flag.
  - Reused by future unary stream generators.

Test Plan (BITWIDTH=8, WINLOG=8):
1. Reset, iStart pulse, iBit=1 for 256 enabled cycles -> one oValid pulse, oValue=255 (saturated), oBusy low afterwards.
2. iBit=1 for the first 134 samples, then 0 -> oValue=134; alternating 1,0 stream -> oValue=128; all-zero stream -> oValue=0 with oValid still pulsed.
3. iEn toggled off for 500 cycles mid-window with iBit=1 -> counters frozen, no oValid; the result equals the count of enabled '1' samples only, and completion is delayed by exactly 500 cycles.
4. iClr asserted at sample 100 -> oBusy drops next cycle, oValue=0, no oValid; iStart and iClr asserted in the same cycle -> state stays IDLE.
5. iStart held high through DONE -> second window starts immediately with zero gap; second result independent of the first (for example 64 then 200).
6. iRstN pulsed low mid-window -> outputs 0 asynchronously; after release a fresh window decodes correctly (for example 134).
